op_downscale: RTL and testbench
===============================

// Module: op_downscale
// PURPOSE
// - Return path of the CORDIC datapath: takes CORDIC_WIDTH signed x/y results and reduces them to DATA_WIDTH.
// - Drops FRAC = CORDIC_WIDTH-DATA_WIDTH guard LSBs, applying rounding and saturation.
// - Decoupled by a 2-entry registered buffer with valid/ready on both sides.
// - Sits between the CORDIC core output and the DATA_WIDTH consumers.
// PARAMETERS
// - DATA_WIDTH    16  output sample width, signed two's complement
// - CORDIC_WIDTH  22  input sample width, signed; must be > DATA_WIDTH
// - ROUND_MODE    1   0 = truncate (floor), 1 = round-half-up (+0.5 LSB then floor), 2 = convergent (ties to even)
// PORTS
// - clk       in   1               rising-edge clock
// - nreset    in   1               asynchronous active-low reset
// - x_in      in   CORDIC_WIDTH    signed x from CORDIC core
// - y_in      in   CORDIC_WIDTH    signed y from CORDIC core
// - in_vld    in   1               x_in/y_in valid
// - in_rdy    out  1               block can accept a sample this cycle
// - x_out     out  DATA_WIDTH      rounded/saturated x
// - y_out     out  DATA_WIDTH      rounded/saturated y
// - sat_out   out  2               {y_sat, x_sat} for the sample on x_out/y_out
// - op_vld    out  1               x_out/y_out/sat_out valid
// - op_rdy    in   1               consumer accepts output this cycle
// - clr_ovf   in   1               synchronous clear of ovf_sticky
// - ovf_sticky out 1               set when any accepted sample saturated
// BEHAVIOUR
// - Reset (nreset=0, async): buffer emptied; count=0; op_vld=0; in_rdy=1 after release.
//   x_out=0, y_out=0, sat_out=0, ovf_sticky=0.
// - Arithmetic: per channel, sign-extend to CORDIC_WIDTH+1, then by mode:
//   - Mode 0: add 0.
//   - Mode 1: add 2^(FRAC-1).
//   - Mode 2: add 2^(FRAC-1)-1, plus bit FRAC of input (ties to even).
//   - Arithmetic shift right by FRAC.
//   - Result > 2^(DATA_WIDTH-1)-1 -> clamp to max, sat bit=1.
//   - Result < -2^(DATA_WIDTH-1) -> clamp to min, sat bit=1.
//   - Otherwise low DATA_WIDTH bits, sat bit=0.
// - Rounding/saturation is combinational on the input and written into the buffer at the push edge.
// - Buffer: 2 entries {x, y, sat}, wr/rd pointers 1 bit each, count 0..2.
// - push = in_vld & in_rdy; pop = op_vld & op_rdy.
// - in_rdy = (count != 2), a registered-state function only; no combinational path from op_rdy.
// - op_vld = (count != 0). x_out/y_out/sat_out show the head entry.
// - Outputs hold stable while op_vld=1 and op_rdy=0.
// - Latency: sample pushed at edge N is visible on outputs after edge N (next cycle) when the buffer was empty.
// - Throughput: 1 sample/cycle sustained while op_rdy=1.
// - Count transitions:
//   - push & pop: count unchanged, both pointers advance.
//   - count=0, pop impossible (op_vld=0).
//   - count=2: push impossible (in_rdy=0). in_rdy rises the cycle after the pop.
// - Output fields when op_vld=0 keep the last popped values; don't-care for checking.
// - ovf_sticky is set at a push edge with any sat bit=1, cleared by clr_ovf.
//   Simultaneous set and clr_ovf in the same cycle: set wins.
// - Reset mid-stream: all buffered samples discarded, no partial output.
// TESTING
// - D=16/C=22/mode1: push x_in=22'h000020, y_in=22'h000060.
//   -> next cycle op_vld=1, x_out=16'h0001, y_out=16'h0002, sat_out=0.
// - Mode 2 ties: x_in=22'h000020 -> 16'h0000; y_in=22'h000060 -> 16'h0002.
//   Mode 0: x_in=22'h00003F -> 16'h0000; x_in=22'h3FFFC1 -> 16'hFFFF.
// - Saturation, mode1: x_in=22'h1FFFFF -> x_out=16'h7FFF, sat_out[0]=1, ovf_sticky=1 next cycle.
//   y_in=22'h200000 -> 16'h8000, sat_out[1]=0.
// - Backpressure: op_rdy=0, push 3 back-to-back samples -> in_rdy=0 after 2 pushes.
//   Raise op_rdy -> samples emerge in order, none lost or duplicated.
//   Then stream 100 samples with op_rdy=1 -> 1 per cycle.
// - Simultaneous clr_ovf=1 and a saturating push -> ovf_sticky=1.
//   clr_ovf alone next cycle -> ovf_sticky=0.
// - Assert nreset with count=2 mid-stream -> op_vld=0, outputs 0, ovf_sticky=0 immediately.
//   After release in_rdy=1 and the next push is output correctly.

Source files
------------

// File: rtl/op_downscale.sv
// CORDIC return path: rounds and saturates CORDIC_WIDTH x/y samples down to DATA_WIDTH,
// decoupled from the consumer by a 2-entry registered buffer with valid/ready on both sides.
module op_downscale #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned CORDIC_WIDTH = 22,
  parameter int unsigned ROUND_MODE   = 1
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [CORDIC_WIDTH-1:0] x_in,
  input  logic [CORDIC_WIDTH-1:0] y_in,
  input  logic                    in_vld,
  output logic                    in_rdy,
  output logic [DATA_WIDTH-1:0]   x_out,
  output logic [DATA_WIDTH-1:0]   y_out,
  output logic [1:0]              sat_out,
  output logic                    op_vld,
  input  logic                    op_rdy,
  input  logic                    clr_ovf,
  output logic                    ovf_sticky
);

  localparam int unsigned Frac = CORDIC_WIDTH - DATA_WIDTH;
  localparam int unsigned ExtW = CORDIC_WIDTH + 1;

  typedef logic signed [ExtW-1:0] ext_t;

  localparam ext_t Half   = ext_t'(1) << (Frac - 1);
  localparam ext_t MaxVal = ext_t'((longint'(1) << (DATA_WIDTH - 1)) - 1);
  localparam ext_t MinVal = ext_t'(-(longint'(1) << (DATA_WIDTH - 1)));

  // Returns {sat, value}; one extra headroom bit keeps the bias add from wrapping.
  function automatic logic [DATA_WIDTH:0] downscale(input logic [CORDIC_WIDTH-1:0] v);
    ext_t                  ext;
    ext_t                  bias;
    ext_t                  shifted;
    logic [DATA_WIDTH:0]   res;
    ext  = ext_t'($signed(v));
    bias = '0;
    if (ROUND_MODE == 1) begin
      bias = Half;
    end else if (ROUND_MODE == 2) begin
      bias = Half - ext_t'(1) + ext_t'(v[Frac]);
    end
    shifted = (ext + bias) >>> Frac;
    if (shifted > MaxVal) begin
      res = {1'b1, MaxVal[DATA_WIDTH-1:0]};
    end else if (shifted < MinVal) begin
      res = {1'b1, MinVal[DATA_WIDTH-1:0]};
    end else begin
      res = {1'b0, shifted[DATA_WIDTH-1:0]};
    end
    return res;
  endfunction

  logic [DATA_WIDTH:0]   x_ds;
  logic [DATA_WIDTH:0]   y_ds;
  logic [DATA_WIDTH-1:0] x_mem_q [2];
  logic [DATA_WIDTH-1:0] y_mem_q [2];
  logic [1:0]            sat_mem_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic                  ovf_q;
  logic                  ovf_d;
  logic                  push;
  logic                  pop;

  assign x_ds = downscale(x_in);
  assign y_ds = downscale(y_in);

  // Ready depends only on registered occupancy, never on op_rdy.
  assign in_rdy = (count_q != 2'd2);
  assign op_vld = (count_q != 2'd0);
  assign push   = in_vld & in_rdy;
  assign pop    = op_vld & op_rdy;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // A saturating push takes priority over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (push && (x_ds[DATA_WIDTH] || y_ds[DATA_WIDTH])) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      x_mem_q[0]   <= '0;
      x_mem_q[1]   <= '0;
      y_mem_q[0]   <= '0;
      y_mem_q[1]   <= '0;
      sat_mem_q[0] <= '0;
      sat_mem_q[1] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      ovf_q        <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (push) begin
        x_mem_q[wr_ptr_q]   <= x_ds[DATA_WIDTH-1:0];
        y_mem_q[wr_ptr_q]   <= y_ds[DATA_WIDTH-1:0];
        sat_mem_q[wr_ptr_q] <= {y_ds[DATA_WIDTH], x_ds[DATA_WIDTH]};
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign x_out      = x_mem_q[rd_ptr_q];
  assign y_out      = y_mem_q[rd_ptr_q];
  assign sat_out    = sat_mem_q[rd_ptr_q];
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_op_downscale.sv
// Bench for op_downscale: three instances (one per rounding mode) share stimulus; a scoreboard
// queue holds expected outputs for all three and is checked whenever a sample is popped.
module tb_op_downscale;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic [21:0] x_in = '0;
  logic [21:0] y_in = '0;
  logic        in_vld = 1'b0;
  logic        op_rdy = 1'b0;
  logic        clr_ovf = 1'b0;

  logic        in_rdy_m [3];
  logic [15:0] x_out_m [3];
  logic [15:0] y_out_m [3];
  logic [1:0]  sat_m [3];
  logic        op_vld_m [3];
  logic        ovf_m [3];

  logic in_rdy;
  logic op_vld;
  assign in_rdy = in_rdy_m[1];
  assign op_vld = op_vld_m[1];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    op_downscale #(
      .DATA_WIDTH  (16),
      .CORDIC_WIDTH(22),
      .ROUND_MODE  (k)
    ) u_dut (
      .clk       (clk),
      .nreset    (nreset),
      .x_in      (x_in),
      .y_in      (y_in),
      .in_vld    (in_vld),
      .in_rdy    (in_rdy_m[k]),
      .x_out     (x_out_m[k]),
      .y_out     (y_out_m[k]),
      .sat_out   (sat_m[k]),
      .op_vld    (op_vld_m[k]),
      .op_rdy    (op_rdy),
      .clr_ovf   (clr_ovf),
      .ovf_sticky(ovf_m[k])
    );
  end

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_pop = 0;
  logic [101:0] exp_q[$];
  logic [101:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: floor((v + bias) / 64) with clamp to 16-bit signed.
  function automatic logic [16:0] model(input int mode, input logic [21:0] v);
    longint e;
    longint r;
    e = longint'($signed(v));
    if (mode == 1) e = e + 32;
    else if (mode == 2) e = e + 31 + longint'(v[6]);
    r = e >>> 6;
    if (r > 32767) return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  function automatic logic [101:0] expect_all(input logic [21:0] x, input logic [21:0] y);
    logic [101:0] r;
    logic [16:0]  mx;
    logic [16:0]  my;
    r = '0;
    for (int m = 0; m < 3; m++) begin
      mx = model(m, x);
      my = model(m, y);
      r[m*34 +: 34] = {my[16], mx[16], my[15:0], mx[15:0]};
    end
    return r;
  endfunction

  // Scoreboard monitor: inputs change #1 after posedge, so negedge sees the values of the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (nreset) begin
        if (op_vld && op_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_unexpected: op_vld=1 with empty scoreboard, x_out=%h", x_out_m[1]);
          end else begin
            mon_e = exp_q.pop_front();
            n_pop++;
            for (int k = 0; k < 3; k++) begin
              checks++;
              if ({sat_m[k], y_out_m[k], x_out_m[k]} !== mon_e[k*34 +: 34]) begin
                failures++;
                $display("FAIL pop_data mode%0d: got sat=%b y=%h x=%h exp sat=%b y=%h x=%h", k,
                         sat_m[k], y_out_m[k], x_out_m[k], mon_e[k*34+32 +: 2],
                         mon_e[k*34+16 +: 16], mon_e[k*34 +: 16]);
              end
            end
          end
        end
        if (in_vld && in_rdy) exp_q.push_back(expect_all(x_in, y_in));
      end
    end
  end

  task automatic send(input logic [21:0] x, input logic [21:0] y);
    int n;
    n = 0;
    x_in = x;
    y_in = y;
    in_vld = 1'b1;
    while (!in_rdy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_rdy=%0b exp=1", in_rdy);
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || op_vld) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = (n < 50);
  endtask

  task automatic test_reset();
    #1 nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({op_vld, x_out_m[1], y_out_m[1], sat_m[1], ovf_m[1]} !== 36'd0) begin
      failures++;
      $display("FAIL reset_state: got vld=%b x=%h y=%h sat=%b ovf=%b exp all 0", op_vld,
               x_out_m[1], y_out_m[1], sat_m[1], ovf_m[1]);
    end
    @(negedge clk) nreset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_rdy: got %b exp 1", in_rdy);
    end
  endtask

  task automatic test_rounding();
    op_rdy = 1'b1;
    send(22'h000020, 22'h000060);
    checks++;
    if ({op_vld, sat_m[1], y_out_m[1], x_out_m[1]} !== {1'b1, 2'b00, 16'h0002, 16'h0001}) begin
      failures++;
      $display("FAIL round_half_up: got vld=%b sat=%b y=%h x=%h exp 1 00 0002 0001", op_vld,
               sat_m[1], y_out_m[1], x_out_m[1]);
    end
    checks++;
    if ({y_out_m[2], x_out_m[2]} !== {16'h0002, 16'h0000}) begin
      failures++;
      $display("FAIL round_even: got y=%h x=%h exp 0002 0000", y_out_m[2], x_out_m[2]);
    end
    send(22'h00003F, 22'h3FFFC1);
    checks++;
    if ({y_out_m[0], x_out_m[0]} !== {16'hFFFF, 16'h0000}) begin
      failures++;
      $display("FAIL trunc: got y=%h x=%h exp FFFF 0000", y_out_m[0], x_out_m[0]);
    end
    checks++;
    if ({y_out_m[1], x_out_m[1]} !== {16'hFFFF, 16'h0001}) begin
      failures++;
      $display("FAIL round_half_up_neg: got y=%h x=%h exp FFFF 0001", y_out_m[1], x_out_m[1]);
    end
  endtask

  task automatic test_saturation();
    send(22'h1FFFFF, 22'h200000);
    checks++;
    if ({sat_m[1], y_out_m[1], x_out_m[1], ovf_m[1]} !== {2'b01, 16'h8000, 16'h7FFF, 1'b1}) begin
      failures++;
      $display("FAIL sat_mode1: got sat=%b y=%h x=%h ovf=%b exp 01 8000 7FFF 1", sat_m[1],
               y_out_m[1], x_out_m[1], ovf_m[1]);
    end
    checks++;
    if ({sat_m[0], x_out_m[0], ovf_m[0]} !== {2'b00, 16'h7FFF, 1'b0}) begin
      failures++;
      $display("FAIL nosat_mode0: got sat=%b x=%h ovf=%b exp 00 7FFF 0", sat_m[0], x_out_m[0],
               ovf_m[0]);
    end
  endtask

  task automatic test_ovf_clear();
    bit ok;
    wait_drain(ok);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (ovf_m[1] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: got %b exp 0", ovf_m[1]);
    end
    send(22'h1FFFFF, 22'h000000);
    checks++;
    if (ovf_m[1] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set_wins: got %b exp 1", ovf_m[1]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (ovf_m[1] !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear_after: got %b exp 0", ovf_m[1]);
    end
    clr_ovf = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int p0;
    wait_drain(ok);
    op_rdy = 1'b0;
    p0 = n_pop;
    send(22'h000100, 22'h3FFF00);
    send(22'h000200, 22'h000040);
    checks++;
    if ({in_rdy, op_vld} !== 2'b01) begin
      failures++;
      $display("FAIL bp_full: got in_rdy=%b op_vld=%b exp 0 1", in_rdy, op_vld);
    end
    x_in = 22'h000300;
    y_in = 22'h3FFE00;
    in_vld = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if ({in_rdy, y_out_m[1], x_out_m[1]} !== {1'b0, 16'hFFFC, 16'h0004}) begin
      failures++;
      $display("FAIL bp_hold: got in_rdy=%b y=%h x=%h exp 0 FFFC 0004", in_rdy, y_out_m[1],
               x_out_m[1]);
    end
    op_rdy = 1'b1;
    send(22'h000300, 22'h3FFE00);
    wait_drain(ok);
    checks++;
    if (!ok || (n_pop - p0) != 3) begin
      failures++;
      $display("FAIL bp_drain: got drained=%0b pops=%0d exp 1 3", ok, n_pop - p0);
    end
  endtask

  task automatic test_stream();
    bit ok;
    int p0;
    int c0;
    logic [31:0] rx;
    logic [31:0] ry;
    op_rdy = 1'b1;
    p0 = n_pop;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      rx = $urandom;
      ry = $urandom;
      if (i % 10 == 0) rx[21:0] = 22'h1FFFE0;
      send(rx[21:0], ry[21:0]);
    end
    checks++;
    if ((cyc - c0) != 100) begin
      failures++;
      $display("FAIL stream_rate: got %0d cycles exp 100", cyc - c0);
    end
    wait_drain(ok);
    checks++;
    if (!ok || (n_pop - p0) != 100) begin
      failures++;
      $display("FAIL stream_count: got drained=%0b pops=%0d exp 1 100", ok, n_pop - p0);
    end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    op_rdy = 1'b0;
    send(22'h1FFFFF, 22'h000040);
    send(22'h000080, 22'h000000);
    checks++;
    if ({in_rdy, ovf_m[1]} !== 2'b01) begin
      failures++;
      $display("FAIL mid_pre: got in_rdy=%b ovf=%b exp 0 1", in_rdy, ovf_m[1]);
    end
    nreset = 1'b0;
    #1;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({op_vld_m[k], x_out_m[k], y_out_m[k], sat_m[k], ovf_m[k]} !== 36'd0) begin
        failures++;
        $display("FAIL mid_reset mode%0d: got vld=%b x=%h y=%h sat=%b ovf=%b exp all 0", k,
                 op_vld_m[k], x_out_m[k], y_out_m[k], sat_m[k], ovf_m[k]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk) nreset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({in_rdy, op_vld} !== 2'b10) begin
      failures++;
      $display("FAIL mid_release: got in_rdy=%b op_vld=%b exp 1 0", in_rdy, op_vld);
    end
    op_rdy = 1'b1;
    send(22'h000040, 22'h000080);
    checks++;
    if ({op_vld, sat_m[1], y_out_m[1], x_out_m[1]} !== {1'b1, 2'b00, 16'h0002, 16'h0001}) begin
      failures++;
      $display("FAIL mid_next: got vld=%b sat=%b y=%h x=%h exp 1 00 0002 0001", op_vld,
               sat_m[1], y_out_m[1], x_out_m[1]);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_drain: got drained=0 exp 1");
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_ovf_clear();
    test_backpressure();
    test_stream();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
